// File: rtl/ahb_sif_pkg.sv
// Shared AHB-Lite encodings and lane-mask helper for the system-interface memory model.
package ahb_sif_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic [31:0] DEFAULT_MAILBOX_ADDR = 32'hD058_0000;

    // Sizes above a dword collapse to a dword; lanes shifted past bit 7 are dropped.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
        logic [15:0] base;
        case (size)
            HSIZE_BYTE: base = 16'h0001;
            HSIZE_HALF: base = 16'h0003;
            HSIZE_WORD: base = 16'h000F;
            default:    base = 16'h00FF;
        endcase
        lane_mask = 8'(base << offset);
    endfunction

endpackage

// File: rtl/ahb_sif_lane_dec.sv
// Byte-lane enable decoder: transfer size and dword offset to an 8-bit lane mask.
module ahb_sif_lane_dec
    import ahb_sif_pkg::*;
(
    input  logic [2:0] size,
    input  logic [2:0] offset,
    output logic [7:0] lanes
);

    assign lanes = lane_mask(size, offset);

endmodule

// File: rtl/ahb_sif_mem.sv
// Zero-wait-state AHB-Lite slave memory with a 64-bit data bus and a mailbox write strobe.
module ahb_sif_mem
    import ahb_sif_pkg::*;
#(
    parameter int          MEM_AW       = 16,
    parameter logic [31:0] MAILBOX_ADDR = DEFAULT_MAILBOX_ADDR
) (
    input  logic        core_clk,
    input  logic        reset_l,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [63:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic        mailbox_write,
    output logic [63:0] write_data
);

    logic [7:0] mem [0:(2**MEM_AW)-1];

    logic        acc;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        rd_pend;
    logic        wr_pend;
    logic [7:0]  lanes;

    // Burst/protection attributes carry no meaning for a flat memory.
    logic unused_attr;
    assign unused_attr = ^{HBURST, HPROT, HTRANS[0]};

    assign acc   = HSEL & HREADY & HTRANS[1];
    assign HRESP = 1'b0;

    ahb_sif_lane_dec u_lane_dec (
        .size   (size_q),
        .offset (addr_q[2:0]),
        .lanes  (lanes)
    );

    always_ff @(posedge core_clk or negedge reset_l) begin
        if (!reset_l) begin
            HREADYOUT     <= 1'b0;
            addr_q        <= '0;
            size_q        <= '0;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            mailbox_write <= 1'b0;
            write_data    <= '0;
        end else begin
            // NOTE: non-blocking assignments let the data phase of one transfer read the
            // address/flags latched by the previous edge while the next transfer is captured.
            HREADYOUT     <= 1'b1;
            rd_pend       <= acc & ~HWRITE;
            wr_pend       <= acc & HWRITE;
            mailbox_write <= wr_pend && (addr_q == MAILBOX_ADDR);
            if (acc) begin
                addr_q <= HADDR;
                size_q <= HSIZE;
            end
            if (wr_pend) begin
                write_data <= HWDATA;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto RAM and keeps its preloaded contents;
    // an aborted write is blocked because wr_pend clears asynchronously.
    always_ff @(posedge core_clk) begin
        if (wr_pend) begin
            for (int i = 0; i < 8; i++) begin
                if (lanes[i]) begin
                    mem[{addr_q[MEM_AW-1:3], 3'(i)}] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_pend) begin
            for (int i = 0; i < 8; i++) begin
                HRDATA[8*i +: 8] = mem[{addr_q[MEM_AW-1:3], 3'(i)}];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sif_mem.sv
// Directed self-checking bench for ahb_sif_mem: reset, lane writes, readback, mailbox, aborts.
module tb_ahb_sif_mem;
    import ahb_sif_pkg::*;

    logic        core_clk = 1'b0;
    logic        reset_l;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [63:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        mailbox_write;
    logic [63:0] write_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] rd;

    always #5 core_clk = ~core_clk;

    ahb_sif_mem dut (
        .core_clk      (core_clk),
        .reset_l       (reset_l),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HBURST        (HBURST),
        .HPROT         (HPROT),
        .HREADY        (HREADY),
        .HWDATA        (HWDATA),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .mailbox_write (mailbox_write),
        .write_data    (write_data)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                             input logic [1:0] tr);
        HSEL = 1'b1; HADDR = a; HSIZE = sz; HWRITE = 1'b1; HTRANS = tr;
        tick();
        HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = d;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [63:0] d);
        HSEL = 1'b1; HADDR = a; HSIZE = HSIZE_DWORD; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ;
        tick();
        HTRANS = HTRANS_IDLE;
        d = HRDATA;
        tick();
    endtask

    initial begin
        reset_l = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_BYTE; HBURST = '0; HPROT = '0; HREADY = 1'b1; HWDATA = '0;

        // Reset state
        tick();
        check("rst_hreadyout", 64'(HREADYOUT), 64'd0);
        check("rst_hresp", 64'(HRESP), 64'd0);
        check("rst_hrdata", HRDATA, 64'd0);
        check("rst_mailbox", 64'(mailbox_write), 64'd0);
        check("rst_write_data", write_data, 64'd0);
        reset_l = 1'b1;
        #2;
        check("release_hreadyout_before_edge", 64'(HREADYOUT), 64'd0);
        tick();
        check("release_hreadyout_after_edge", 64'(HREADYOUT), 64'd1);
        check("release_hresp", 64'(HRESP), 64'd0);

        // Byte write into a known dword
        bus_write(32'h0000_0010, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF, HTRANS_NONSEQ);
        bus_write(32'h0000_0013, HSIZE_BYTE, 64'hFFFF_FFFF_A5FF_FFFF, HTRANS_NONSEQ);
        check("write_data_hold", write_data, 64'hFFFF_FFFF_A5FF_FFFF);
        bus_read(32'h0000_0010, rd);
        check("byte_write_lane3", rd, 64'h0123_4567_A5AB_CDEF);
        check("hrdata_idle_zero", HRDATA, 64'd0);

        // Dword write immediately followed by a read of the same address
        HSEL = 1'b1; HADDR = 32'h0000_0008; HSIZE = HSIZE_DWORD; HWRITE = 1'b1; HTRANS = HTRANS_NONSEQ;
        tick();
        HWDATA = 64'h1122_3344_5566_7788; HWRITE = 1'b0; HTRANS = HTRANS_NONSEQ;
        tick();
        HTRANS = HTRANS_IDLE;
        check("write_then_read", HRDATA, 64'h1122_3344_5566_7788);
        tick();

        // Halfword at offset 2, then a dword-size write at offset 4 (upper lanes only)
        bus_write(32'h0000_000A, HSIZE_HALF, 64'h0000_0000_BEEF_0000, HTRANS_NONSEQ);
        bus_read(32'h0000_0008, rd);
        check("half_write", rd, 64'h1122_3344_BEEF_7788);
        bus_write(32'h0000_000C, HSIZE_DWORD, 64'hAAAA_AAAA_BBBB_BBBB, HTRANS_SEQ);
        bus_read(32'h0000_0008, rd);
        check("dword_offset4_truncated", rd, 64'hAAAA_AAAA_BEEF_7788);

        // Mailbox strobe
        bus_write(32'hD058_0000, HSIZE_WORD, 64'h0000_0000_0000_0041, HTRANS_NONSEQ);
        check("mailbox_high", 64'(mailbox_write), 64'd1);
        check("mailbox_data", 64'(write_data[7:0]), 64'h41);
        tick();
        check("mailbox_one_cycle", 64'(mailbox_write), 64'd0);
        check("mailbox_data_holds", write_data, 64'h41);

        // Transfers that must not be accepted
        HREADY = 1'b0;
        bus_write(32'h0000_0008, HSIZE_DWORD, 64'hDEAD_DEAD_DEAD_DEAD, HTRANS_NONSEQ);
        bus_write(32'hD058_0000, HSIZE_WORD, 64'h0000_0000_0000_0042, HTRANS_NONSEQ);
        check("hready0_no_mailbox", 64'(mailbox_write), 64'd0);
        HREADY = 1'b1;
        bus_write(32'h0000_0010, HSIZE_DWORD, 64'hDEAD_DEAD_DEAD_DEAD, HTRANS_IDLE);
        bus_write(32'hD058_0000, HSIZE_WORD, 64'h0000_0000_0000_0043, HTRANS_BUSY);
        check("idle_busy_no_mailbox", 64'(mailbox_write), 64'd0);
        check("ignored_write_data", write_data, 64'h41);
        bus_read(32'h0000_0008, rd);
        check("hready0_mem_unchanged", rd, 64'hAAAA_AAAA_BEEF_7788);
        bus_read(32'h0000_0010, rd);
        check("idle_mem_unchanged", rd, 64'h0123_4567_A5AB_CDEF);

        // Reset during a write data phase discards the write
        HSEL = 1'b1; HADDR = 32'h0000_0010; HSIZE = HSIZE_BYTE; HWRITE = 1'b1; HTRANS = HTRANS_NONSEQ;
        tick();
        HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 64'h0000_0000_0000_0000;
        reset_l = 1'b0;
        #2;
        check("midreset_hreadyout", 64'(HREADYOUT), 64'd0);
        reset_l = 1'b1;
        #1;
        check("midreset_release_hreadyout", 64'(HREADYOUT), 64'd0);
        tick();
        check("midreset_hreadyout_after_edge", 64'(HREADYOUT), 64'd1);
        bus_read(32'h0000_0010, rd);
        check("midreset_write_discarded", rd, 64'h0123_4567_A5AB_CDEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_sif_mem.md
# ahb_sif_mem

Single-port AHB-Lite slave memory model with a 64-bit data bus, used as instruction memory, load/store memory and debug system-bus memory behind the core's AHB masters. Zero-wait-state, always-OKAY responder backed by a byte-addressable array that can be preloaded. It also decodes a mailbox address and raises a one-cycle strobe with the written data, which the bench uses for console output.

## Interface
- MEM_AW, 16: byte-address width of the array (2^MEM_AW bytes); upper HADDR bits ignored for storage (aliasing).
- MAILBOX_ADDR, 32'hD058_0000: full 32-bit address that raises mailbox_write.
- Reset is reset_l, asynchronous, active-low; the clock is core_clk.
- core_clk  in  1  clock
- reset_l  in  1  async active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word, 3 = dword
- HBURST  in  3  ignored
- HPROT  in  4  ignored
- HREADY  in  1  bus ready; address phase accepted only when high
- HWDATA  in  64  write data, valid in data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  always 0 (OKAY)
- HRDATA  out  64  read data
- mailbox_write  out  1  one-cycle strobe after a write to MAILBOX_ADDR
- write_data  out  64  last written HWDATA dword

## Operation
- Accept: acc = HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ). IDLE/BUSY, HSEL=0 or HREADY=0: no transfer, no state change.
- On accept, register HADDR, HSIZE, HWRITE; set rd_pend = ~HWRITE, wr_pend = HWRITE. Pending flags clear on the next edge unless a new transfer is accepted.
- Lane mask: base = 1/3/F/FF for HSIZE 0/1/2/3, shifted left by HADDR[2:0], truncated to 8 bits. HSIZE > 3 treated as 3.
- Write commit, on the edge ending the data phase (wr_pend=1): for each enabled lane i, mem[{addr[MEM_AW-1:3],3'b0}+i] <= HWDATA[8i+7:8i]. write_data <= HWDATA.
- If that write's full address == MAILBOX_ADDR: mailbox_write <= 1 for exactly one cycle. The array is also written (aliased).
- Read: while rd_pend=1, HRDATA = 8 bytes at the aligned latched address, combinational from the array, lane i -> HRDATA[8i+7:8i]. Otherwise HRDATA = 0.
- No error responses; unaligned sizes are not checked, and bytes beyond the dword are dropped.
- The array is not reset. It is a byte array named mem and is preloadable by $readmemh.

## Timing
- Reset values: HREADYOUT 0, HRESP 0, HRDATA 0, mailbox_write 0, write_data 0, pending flags 0.
- HREADYOUT is registered and goes to 1 at the first core_clk edge after reset_l deasserts. It then stays 1 (no wait states).
- Pipelining: address phase at edge N; data phase is cycle N..N+1.
  - Write commits at edge N+1.
  - Read data is valid in the cycle after edge N.
  - Back-to-back transfers every cycle are supported.
- Read in the cycle right after a write commit to the same address returns the new data.
- mailbox_write is high during the cycle after the commit edge. write_data is stable through that cycle and holds until the next write.
- reset_l asserted mid data phase: the pending write is discarded and flags clear asynchronously.

## Structure
- Package ahb_sif_pkg holds:
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - HSIZE encodings
  - default MAILBOX_ADDR
  - a lane-mask function
- One natural sub-module: ahb_sif_lane_dec (HSIZE, addr[2:0] -> 8-bit lane mask).

## Test plan
- Reset release -> HREADYOUT 0 during reset, 1 one edge after release; HRESP stays 0.
- Byte write 0xA5 to 0x0000_0013, then dword read at 0x0000_0010 -> HRDATA[31:24]=0xA5, other bytes keep their prior values.
- Dword write 0x1122334455667788 at 0x08, immediately followed by a read at 0x08 -> HRDATA=0x1122334455667788 in the next data phase.
- Word write 0x41 to 0xD058_0000 -> mailbox_write high exactly one cycle, with write_data[7:0]=0x41 while high.
- NONSEQ write with HREADY=0, or with HTRANS=IDLE -> memory unchanged, mailbox_write stays 0.
- reset_l pulsed low during a write's data phase -> target bytes unchanged; HREADYOUT 0 until the edge after reset release.
